arith_seq: RTL and testbench
============================

Name: arith_seq

Overview:
- Multi-cycle sequencer that issues wide add/sub/compare/pass operations to an 8-bit add slice, one byte per cycle, chaining the carry between slices.
- Accepts a command over a valid/ready handshake, runs it, and presents the registered result and flags (C, V, Z, eq, gr, ls) over a second valid/ready handshake.
- It is the command-issuing end of the 8-bit arithmetic datapath. It lets the datapath serve a 16-bit register file and branch unit.

Parameters:
- SLICE_W, 8: width of the arithmetic slice in bits.
- NSLICE, 2: number of slices per operation. Operand width is W = SLICE_W*NSLICE.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command.
- cmd_op, input, 2: operation code. 00 ADD, 01 SUB, 10 CMP, 11 PASS.
- cmd_a, input, W: operand a.
- cmd_b, input, W: operand b.
- res_valid, output, 1: result and flags are valid.
- res_ready, input, 1: consumer accepts the result.
- res_f, output, W: result.
- res_C, res_V, res_Z, output, 1 each: carry, signed overflow, zero.
- res_eq, res_gr, res_ls, output, 1 each: unsigned compare of a against b.

Behaviour:
- States and reset:
  - FSM states are IDLE, RUN and DONE, plus slice index idx (0..NSLICE-1).
  - Synchronous reset forces state=IDLE and idx=0. All outputs reset to 0 except cmd_ready, which is 1 in IDLE.
- Command accept:
  - In IDLE, cmd_ready=1. A command is accepted when cmd_valid&cmd_ready is high on an edge.
  - On accept, latch cmd_a, cmd_b and cmd_op, set idx=0 and move to RUN.
  - cmd_ready=0 in RUN and DONE. No command is accepted while busy.
- Slice operand and carry-in selection:
  - ADD: b_slice = b[idx].
  - SUB and CMP: b_slice = ~b[idx].
  - Carry-in at idx=0: 0 for ADD, 1 for SUB/CMP.
  - Carry-in at idx>0: carry-out of the previous slice, taken from a carry register.
- RUN, per cycle:
  - Compute slice idx, write its sum into f_reg[idx], and store the carry-out.
  - If idx==NSLICE-1, go to DONE. Otherwise increment idx.
- Latency: res_valid rises exactly NSLICE+1 edges after the accept edge (3 edges for the defaults).
- PASS:
  - Still steps through RUN for NSLICE cycles, with f slice = b slice.
  - C=0, V=0, Z=(b==0).
- Flags, registered when entering DONE:
  - C: carry out of bit W-1. For SUB/CMP, C=1 means no borrow.
  - V: (a[W-1]==b_eff[W-1]) && (f[W-1]!=a[W-1]), where b_eff is the inverted b for SUB/CMP.
  - Z: f==0 over all W bits.
- Compare flags:
  - eq, gr and ls are unsigned a vs b and are valid for all four ops.
  - They come from the latched operands and are one-hot: exactly one is set.
- Result by op:
  - ADD, SUB, PASS: res_f = computed value.
  - CMP: res_f also carries a-b; the consumer ignores it.
- DONE:
  - res_valid=1; res_f and all flags are held stable while res_valid&!res_ready.
  - On res_valid&res_ready, go to IDLE. res_valid drops next cycle, and cmd_ready=1 that same cycle.
  - No same-cycle re-accept: a new command needs cmd_ready=1 in IDLE.
- Outputs in IDLE/RUN: res_f and the flags keep the last completed values; res_valid=0.
- Reset mid-operation: rst in RUN or DONE aborts the operation. The result is discarded and outputs are zeroed next edge.
- Reset priority: rst has priority over every handshake in the same cycle.
- Wrap-around: arithmetic is modulo 2^W, and overflow is reported only via C and V.

Decomposition:
- Shared package arith_pkg holds:
  - op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_PASS=2'b11;
  - FSM state encodings S_IDLE, S_RUN, S_DONE;
  - default SLICE_W and NSLICE.
- One sub-module, arith_slice: combinational SLICE_W-bit adder with inputs a, b, cin and outputs sum, cout, and msb carry-in for V.
- arith_seq instantiates it once and time-multiplexes it across slices.

Test Plan:
- ADD a=0x00FF, b=0x0001, res_ready=1 -> res_valid 3 edges after accept; f=0x0100, C=0, V=0, Z=0, gr=1.
- ADD a=0xFFFF, b=0x0001 -> f=0x0000, C=1, V=0, Z=1, gr=1.
- SUB a=0x8000, b=0x0001 -> f=0x7FFF, C=1, V=1, Z=0, gr=1. Also SUB 0x1234-0x1234 -> f=0, Z=1, C=1, eq=1.
- CMP a=0x1234, b=0x1235 -> f=0xFFFF, C=0, ls=1, eq=0, gr=0. PASS b=0x0000 -> f=0, Z=1, C=0, V=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, f and flags stable, cmd_ready=0, and a cmd_valid pulse is ignored. Release -> IDLE next edge, then a new command is accepted.
- Assert rst for one cycle while idx=1 in RUN -> next edge: state IDLE, res_valid=0, f=0, flags=0, cmd_ready=1. A following ADD completes correctly.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// arith_pkg: shared definitions for the arith_seq codebase slice.
//   - op codes carried on cmd_op
//   - FSM state encodings used by the sequencer
//   - default slice width and slice count
//   - helper that picks the carry-in for the first slice of an op
package arith_pkg;

  localparam int SLICE_W_DEF = 8;
  localparam int NSLICE_DEF  = 2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Subtraction is a + ~b + 1, so the "+1" enters as carry-in of slice 0.
  function automatic logic cin_first(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/arith_seq_if.sv
// arith_seq_if: command and result handshakes of the arith_seq sequencer.
//   cmd_*  : valid/ready command channel (op, operand a, operand b)
//   res_*  : valid/ready result channel (result f and flags C V Z eq gr ls)
// Modports:
//   master : the command issuer / result consumer
//   slave  : the sequencer itself
interface arith_seq_if import arith_pkg::*; #(
  parameter int W = SLICE_W_DEF * NSLICE_DEF
) ();

  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_f;
  logic         res_C;
  logic         res_V;
  logic         res_Z;
  logic         res_eq;
  logic         res_gr;
  logic         res_ls;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_f, res_C, res_V, res_Z,
           res_eq, res_gr, res_ls
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_f, res_C, res_V, res_Z,
           res_eq, res_gr, res_ls
  );

endinterface

// File: rtl/arith_seq_slice.sv
// arith_slice: combinational SLICE_W-bit adder slice.
//   a, b  : slice operands (b already inverted by the caller for subtract)
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the slice msb
//   cmsb  : carry into the slice msb; cout ^ cmsb is signed overflow
module arith_slice import arith_pkg::*; #(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  logic [SLICE_W:0]   full;
  logic [SLICE_W-1:0] low;

  assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

  // Same addition without the msb: its top bit is the carry into the msb.
  assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]}
              + {{(SLICE_W-1){1'b0}}, cin};

  assign sum  = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];
  assign cmsb = low[SLICE_W-1];

endmodule

// File: rtl/arith_seq.sv
// arith_seq: multi-cycle wide add/sub/compare/pass sequencer.
// One shared SLICE_W-bit adder slice is stepped over NSLICE slices, chaining
// the carry through a register. The result and flags are registered and
// presented on the result handshake; res_valid rises NSLICE+1 edges after
// the command is accepted.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : arith_seq_if.slave (command and result handshakes)
module arith_seq import arith_pkg::*; #(
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int NSLICE  = NSLICE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  arith_seq_if.slave  bus
);

  localparam int W    = SLICE_W * NSLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  logic [1:0]      op_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    f_work;
  logic            carry_reg;

  logic [W-1:0]    res_f_r;
  logic            res_valid_r;
  logic            c_r, v_r, z_r, eq_r, gr_r, ls_r;

  logic [SLICE_W-1:0] a_sl, b_sl, sum_sl;
  logic               cin_sl, cout_sl, cmsb_sl;
  logic [W-1:0]       f_next;
  logic               c_fin, v_fin;

  // Operand selection for the current slice. PASS feeds a=0 so the slice
  // simply forwards b and can never produce a carry.
  always_comb begin
    a_sl   = a_reg[int'(idx)*SLICE_W +: SLICE_W];
    b_sl   = b_reg[int'(idx)*SLICE_W +: SLICE_W];
    cin_sl = carry_reg;
    case (op_reg)
      OP_SUB, OP_CMP: b_sl = ~b_reg[int'(idx)*SLICE_W +: SLICE_W];
      OP_PASS:        a_sl = '0;
      default:        ;
    endcase
    if (idx == '0) cin_sl = cin_first(op_reg);
  end

  arith_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (cin_sl),
    .sum  (sum_sl),
    .cout (cout_sl),
    .cmsb (cmsb_sl)
  );

  // Working result with the current slice merged in; on the last slice
  // this is the complete W-bit result.
  always_comb begin
    f_next = f_work;
    f_next[int'(idx)*SLICE_W +: SLICE_W] = sum_sl;
  end

  assign c_fin = (op_reg == OP_PASS) ? 1'b0 : cout_sl;
  assign v_fin = (op_reg == OP_PASS) ? 1'b0 : (cout_sl ^ cmsb_sl);

  // Sequencer. Result and flags are loaded on the edge that enters DONE;
  // res_valid follows one edge later and stays until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      op_reg      <= OP_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      f_work      <= '0;
      carry_reg   <= 1'b0;
      res_f_r     <= '0;
      res_valid_r <= 1'b0;
      c_r         <= 1'b0;
      v_r         <= 1'b0;
      z_r         <= 1'b0;
      eq_r        <= 1'b0;
      gr_r        <= 1'b0;
      ls_r        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_reg <= bus.cmd_op;
            a_reg  <= bus.cmd_a;
            b_reg  <= bus.cmd_b;
            idx    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          f_work    <= f_next;
          carry_reg <= cout_sl;
          if (idx == IDX_LAST) begin
            idx     <= '0;
            state   <= S_DONE;
            res_f_r <= f_next;
            c_r     <= c_fin;
            v_r     <= v_fin;
            z_r     <= (f_next == '0);
            eq_r    <= (a_reg == b_reg);
            gr_r    <= (a_reg > b_reg);
            ls_r    <= (a_reg < b_reg);
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
          end else if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.res_valid = res_valid_r;
  assign bus.res_f     = res_f_r;
  assign bus.res_C     = c_r;
  assign bus.res_V     = v_r;
  assign bus.res_Z     = z_r;
  assign bus.res_eq    = eq_r;
  assign bus.res_gr    = gr_r;
  assign bus.res_ls    = ls_r;

endmodule

// File: tb/tb_arith_seq.sv
// tb_arith_seq: self-checking bench for arith_seq.
// Expected results come from a full-width reference model and are queued when
// a command is accepted, then popped and compared when res_valid appears.
module tb_arith_seq;
  import arith_pkg::*;

  localparam int W = SLICE_W_DEF * NSLICE_DEF;

  typedef struct {
    logic [W-1:0] f;
    logic [5:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cmp_count = 0;
  int   err_count = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  arith_seq_if bus ();

  arith_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: flags packed as {C, V, Z, eq, gr, ls}.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [W:0]   full;
    logic [W-1:0] beff;
    logic c, v, z;
    beff = b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD:         full = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: begin
        beff = ~b;
        full = {1'b0, a} + {1'b0, beff} + (W+1)'(1);
      end
      default:        full = {1'b0, b};
    endcase
    e.f = full[W-1:0];
    if (op != OP_PASS) begin
      c = full[W];
      v = (a[W-1] == beff[W-1]) && (e.f[W-1] != a[W-1]);
    end
    z = (e.f == '0);
    e.flags = {c, v, z, a == b, a > b, a < b};
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmp_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {bus.res_C, bus.res_V, bus.res_Z, bus.res_eq, bus.res_gr, bus.res_ls};
  endfunction

  // Drives one command and returns 1 after its accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called 1 after the accept edge; waits for res_valid and checks latency.
  task automatic waitResult(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) checkOutput({tag, "_busy_ready"}, 32'(bus.cmd_ready), 32'd0);
    end while (!bus.res_valid && n < 20);
    checkOutput({tag, "_latency"}, 32'(n), 32'(NSLICE_DEF + 1));
  endtask

  task automatic collectResult(input string tag);
    exp_t e;
    checkOutput({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, "_f"}, 32'(bus.res_f), 32'(e.f));
    checkOutput({tag, "_flags"}, 32'(dut_flags()), 32'(e.flags));
  endtask

  // Full command with an always-ready consumer.
  task automatic runCmd(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    bus.res_ready = 1'b1;
    applyStimulus(op, a, b);
    waitResult(tag);
    collectResult(tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] held_f;
    logic [5:0]   held_flags;
    exp_t         junk;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_f", 32'(bus.res_f), 32'd0);
    checkOutput("rst_flags", 32'(dut_flags()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runCmd("add_carry", OP_ADD, 16'h00FF, 16'h0001);
    runCmd("add_wrap", OP_ADD, 16'hFFFF, 16'h0001);
    runCmd("sub_ovf", OP_SUB, 16'h8000, 16'h0001);
    runCmd("sub_zero", OP_SUB, 16'h1234, 16'h1234);
    runCmd("cmp_less", OP_CMP, 16'h1234, 16'h1235);
    runCmd("pass_zero", OP_PASS, 16'hABCD, 16'h0000);
    runCmd("pass_val", OP_PASS, 16'h0000, 16'h8001);
    runCmd("add_sovf", OP_ADD, 16'h7FFF, 16'h0001);

    for (int i = 0; i < 6; i++) begin
      runCmd("rand", 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end

    // Backpressure: result held 5 cycles, stray command ignored.
    bus.res_ready = 1'b0;
    applyStimulus(OP_ADD, 16'h1111, 16'h2222);
    waitResult("bp");
    held_f     = bus.res_f;
    held_flags = dut_flags();
    collectResult("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cmd_valid = (i == 2);
      bus.cmd_op    = OP_SUB;
      bus.cmd_a     = 16'h5555;
      bus.cmd_b     = 16'h0001;
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("bp_hold_f", 32'(bus.res_f), 32'(held_f));
      checkOutput("bp_hold_flags", 32'(dut_flags()), 32'(held_flags));
      checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
    runCmd("after_bp", OP_SUB, 16'h0003, 16'h0005);

    // Reset while the second slice is in progress.
    applyStimulus(OP_ADD, 16'h4321, 16'h1111);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("midrst_f", 32'(bus.res_f), 32'd0);
    checkOutput("midrst_flags", 32'(dut_flags()), 32'd0);
    checkOutput("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    if (exp_q.size() > 0) junk = exp_q.pop_front();
    @(negedge clk);
    rst = 1'b0;
    runCmd("after_rst", OP_ADD, 16'h0102, 16'h0304);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
